// File: rtl/spi_cmd_pkg.sv
// ============================================================================
// spi_cmd_pkg: opcodes, FSM state encoding and defaults for spi_cmd_decoder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package spi_cmd_pkg;

  localparam int ADDR_W_DEFAULT = 17;

  localparam logic [3:0] OP_NOP        = 4'h0;
  localparam logic [3:0] OP_WRITE      = 4'h1;
  localparam logic [3:0] OP_READ       = 4'h2;
  localparam logic [3:0] OP_WRITE_NEXT = 4'h3;
  localparam logic [3:0] OP_READ_NEXT  = 4'h4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR_HI  = 3'd1,
    ST_ADDR_LO  = 3'd2,
    ST_DATA     = 3'd3,
    ST_BUS_REQ  = 3'd4,
    ST_BUS_WAIT = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_cmd_decoder_sync_edge.sv
// ============================================================================
// sync_edge: multi-flop synchronizer with a rising-edge pulse on its output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              level_q;

  if (STAGES < 2) begin : g_stages_check
    $error("sync_edge: STAGES must be at least 2");
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], async_in};
      level_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~level_q;

endmodule

`default_nettype wire

// File: rtl/spi_cmd_decoder.sv
// ============================================================================
// spi_cmd_decoder: SPI byte stream to bus transactions; SPI_CMD_AUTOINC_EN adds
// WRITE_NEXT/READ_NEXT. Revision: 1.0
// ============================================================================
`default_nettype none

module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs_n,
  input  logic              spi_done,
  input  logic [7:0]        spi_rx_byte,
  output logic [7:0]        spi_tx_byte,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  output logic              bus_rw_b,
  output logic              bus_strobe,
  input  logic              bus_ack,
  input  logic [7:0]        bus_rdata,
  output logic              cmd_err
);

  state_t            state_q, state_d;
  logic              done_lvl, done_rise, cs_lvl, cs_rise;
  logic              byte_vld, cs_high;
  logic [3:0]        opcode;
  logic              is_read_q;
  logic [ADDR_W-1:0] asm_addr_q, inc_addr, load_addr;
  logic              load_bus, load_rw, bad_op, overrun;

  if (ADDR_W < 17) begin : g_addr_w_check
    $error("spi_cmd_decoder: ADDR_W must be at least 17");
  end

  sync_edge #(.STAGES(SYNC_STAGES)) u_done_sync (
    .clk(clk), .reset(reset), .async_in(spi_done), .level(done_lvl), .rise(done_rise)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .reset(reset), .async_in(spi_cs_n), .level(cs_lvl), .rise(cs_rise)
  );

  assign byte_vld = done_rise & done_lvl;
  assign cs_high  = cs_lvl | cs_rise;
  assign opcode   = spi_rx_byte[7:4];
  assign inc_addr = bus_addr + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    bad_op  = 1'b0;
    overrun = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (byte_vld) begin
          case (opcode)
            OP_NOP:             state_d = ST_IDLE;
            OP_WRITE, OP_READ:  state_d = ST_ADDR_HI;
`ifdef SPI_CMD_AUTOINC_EN
            OP_WRITE_NEXT:      state_d = ST_DATA;
            OP_READ_NEXT:       state_d = ST_BUS_REQ;
`endif
            default:            bad_op  = 1'b1;
          endcase
        end
      end
      ST_ADDR_HI: begin
        if (cs_high)       state_d = ST_IDLE;
        else if (byte_vld) state_d = ST_ADDR_LO;
      end
      ST_ADDR_LO: begin
        if (cs_high)       state_d = ST_IDLE;
        else if (byte_vld) state_d = is_read_q ? ST_BUS_REQ : ST_DATA;
      end
      ST_DATA: begin
        if (cs_high)       state_d = ST_IDLE;
        else if (byte_vld) state_d = ST_BUS_REQ;
      end
      ST_BUS_REQ: begin
        overrun = byte_vld;
        state_d = ST_BUS_WAIT;
      end
      ST_BUS_WAIT: begin
        overrun = byte_vld;
        if (bus_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The low address byte bypasses the assembly register when a READ goes straight to the bus.
  always_comb begin
    load_addr = asm_addr_q;
    load_rw   = is_read_q;
    case (state_q)
      ST_IDLE: begin
        load_addr = inc_addr;
        load_rw   = (opcode == OP_READ_NEXT);
      end
      ST_ADDR_LO: load_addr = {asm_addr_q[ADDR_W-1:8], spi_rx_byte};
      default:    load_addr = asm_addr_q;
    endcase
  end

  assign load_bus = (state_d == ST_BUS_REQ) && (state_q != ST_BUS_REQ);

  always_ff @(posedge clk) begin
    if (reset) begin
      is_read_q   <= 1'b0;
      asm_addr_q  <= '0;
      bus_addr    <= '0;
      bus_wdata   <= 8'h00;
      bus_rw_b    <= 1'b0;
      bus_strobe  <= 1'b0;
      spi_tx_byte <= 8'h00;
      cmd_err     <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && state_d == ST_ADDR_HI) begin
        is_read_q  <= (opcode == OP_READ);
        asm_addr_q <= ADDR_W'({spi_rx_byte[0], 16'h0000});
      end else if (state_q == ST_IDLE && state_d == ST_DATA) begin
        is_read_q  <= 1'b0;
        asm_addr_q <= inc_addr;
      end
      if (state_q == ST_ADDR_HI && state_d == ST_ADDR_LO) asm_addr_q[15:8] <= spi_rx_byte;
      if (state_q == ST_ADDR_LO && state_d == ST_DATA)    asm_addr_q[7:0]  <= spi_rx_byte;
      if (state_q == ST_DATA && state_d == ST_BUS_REQ)    bus_wdata        <= spi_rx_byte;
      if (load_bus) begin
        bus_addr <= load_addr;
        bus_rw_b <= load_rw;
      end
      if (state_q == ST_BUS_REQ) begin
        bus_strobe <= 1'b1;
      end else if (state_q == ST_BUS_WAIT && bus_ack) begin
        bus_strobe <= 1'b0;
        if (bus_rw_b) spi_tx_byte <= bus_rdata;
      end
      if (bad_op || overrun) cmd_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_decoder.sv
// ============================================================================
// tb_spi_cmd_decoder: scoreboard bench with a byte-level command model.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_cmd_decoder;

  localparam int ADDR_W = 17;
`ifdef SPI_CMD_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, spi_cs_n, spi_done, bus_ack;
  logic [7:0]        spi_rx_byte, bus_rdata, spi_tx_byte, bus_wdata;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_rw_b, bus_strobe, cmd_err;

  spi_cmd_decoder dut (
    .clk(clk), .reset(reset), .spi_cs_n(spi_cs_n), .spi_done(spi_done),
    .spi_rx_byte(spi_rx_byte), .spi_tx_byte(spi_tx_byte), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rw_b(bus_rw_b), .bus_strobe(bus_strobe),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic              rw;
  } txn_t;

  txn_t              sb[$];
  int                checks = 0;
  int                errors = 0;
  int                force_delay = -1;
  logic [ADDR_W-1:0] m_base = '0;
  logic              m_err = 1'b0;
  logic [7:0]        m_tx = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cmd_len(input logic [3:0] op);
    case (op)
      4'h1:    return 4;
      4'h2:    return 3;
      4'h3:    return AUTOINC ? 2 : 1;
      default: return 1;
    endcase
  endfunction

  // Expected bus transactions derived from the byte sequence alone.
  task automatic model_cmd(input logic [7:0] b0, b1, b2, b3, input int n);
    int   a;
    txn_t t;
    case (b0[7:4])
      4'h0: ;
      4'h1: if (n >= 4) begin
        a = b0[0] * 65536 + b1 * 256 + b2;
        t = '{addr: ADDR_W'(a), data: b3, rw: 1'b0};
        sb.push_back(t); m_base = t.addr;
      end
      4'h2: if (n >= 3) begin
        a = b0[0] * 65536 + b1 * 256 + b2;
        t = '{addr: ADDR_W'(a), data: 8'h00, rw: 1'b1};
        sb.push_back(t); m_base = t.addr;
      end
      4'h3, 4'h4: begin
        if (!AUTOINC) m_err = 1'b1;
        else if (b0[7:4] == 4'h4 || n >= 2) begin
          a = (int'(m_base) + 1) % (1 << ADDR_W);
          t = '{addr: ADDR_W'(a), data: (b0[7:4] == 4'h3) ? b1 : 8'h00, rw: (b0[7:4] == 4'h4)};
          sb.push_back(t); m_base = t.addr;
        end
      end
      default: m_err = 1'b1;
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b, input bit cs_mid);
    spi_rx_byte = b;
    spi_done    = 1'b1;
    repeat (4) @(negedge clk);
    if (cs_mid) spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    spi_done = 1'b0;
    repeat (8) @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  task automatic run_cmd(input logic [7:0] b0, b1, b2, b3, input int n, input bit cs_mid);
    logic [7:0] b [4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    model_cmd(b0, b1, b2, b3, n);
    for (int k = 0; k < n; k++) send_byte(b[k], cs_mid && (k == n - 1));
    repeat (24) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("cmd_err", 32'(cmd_err), 32'(m_err));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    m_base = '0; m_err = 1'b0; m_tx = 8'h00;
    @(negedge clk);
    check("rst_strobe", 32'(bus_strobe), 32'd0);
    check("rst_rw", 32'(bus_rw_b), 32'd0);
    check("rst_err", 32'(cmd_err), 32'd0);
    check("rst_addr", 32'(bus_addr), 32'd0);
    check("rst_wdata", 32'(bus_wdata), 32'd0);
    check("rst_tx", 32'(spi_tx_byte), 32'd0);
  endtask

  // Bus responder and scoreboard monitor.
  initial begin : bus_agent
    txn_t       exp;
    logic [7:0] rd;
    int         d;
    bus_ack   = 1'b0;
    bus_rdata = 8'h00;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (reset !== 1'b0) continue;
      if (bus_strobe) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: got addr 0x%0h expected no request", bus_addr);
          exp = '0;
        end else begin
          exp = sb.pop_front();
          check("bus_addr", 32'(bus_addr), 32'(exp.addr));
          check("bus_rw_b", 32'(bus_rw_b), 32'(exp.rw));
          if (!exp.rw) check("bus_wdata", 32'(bus_wdata), 32'(exp.data));
        end
        d = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 10));
        repeat (d) begin
          @(negedge clk);
          check("strobe_held", 32'(bus_strobe), 32'd1);
          check("addr_stable", 32'(bus_addr), 32'(exp.addr));
        end
        rd        = 8'($urandom);
        bus_rdata = rd;
        bus_ack   = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        check("strobe_fall", 32'(bus_strobe), 32'd0);
        if (exp.rw) m_tx = rd;
        check("tx_byte", 32'(spi_tx_byte), 32'(m_tx));
      end else if ($urandom_range(0, 7) == 0) begin
        bus_rdata = 8'($urandom);
        bus_ack   = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        check("spurious_ack_tx", 32'(spi_tx_byte), 32'(m_tx));
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [3:0] op;
    int         sel;
    reset       = 1'b1;
    spi_cs_n    = 1'b1;
    spi_done    = 1'b0;
    spi_rx_byte = 8'h00;
    do_reset();
    spi_cs_n = 1'b0;
    repeat (10) @(negedge clk);

    run_cmd(8'h11, 8'h23, 8'h45, 8'hA5, 4, 1'b0);
    run_cmd(8'h20, 8'h80, 8'h00, 8'h00, 3, 1'b0);

    // Partial WRITE aborted by chip select, then a READ must still work.
    model_cmd(8'h10, 8'h12, 8'h00, 8'h00, 2);
    send_byte(8'h10, 1'b0);
    send_byte(8'h12, 1'b0);
    spi_cs_n = 1'b1;
    repeat (10) @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_strobe", 32'(sb.size()), 32'd0);
    run_cmd(8'h20, 8'h00, 8'h01, 8'h00, 3, 1'b0);

    // Host sends a byte while the bus is still waiting for ack.
    force_delay = 40;
    model_cmd(8'h11, 8'h54, 8'h32, 8'h6E, 4);
    send_byte(8'h11, 1'b0); send_byte(8'h54, 1'b0);
    send_byte(8'h32, 1'b0); send_byte(8'h6E, 1'b0);
    m_err = 1'b1;
    send_byte(8'h99, 1'b0);
    repeat (40) @(negedge clk);
    force_delay = -1;
    check("overrun_drained", 32'(sb.size()), 32'd0);
    check("overrun_err", 32'(cmd_err), 32'(m_err));

    do_reset();
    spi_cs_n = 1'b0;
    repeat (10) @(negedge clk);
    run_cmd(8'h70, 8'h00, 8'h00, 8'h00, 1, 1'b0);
    run_cmd(8'h21, 8'hBE, 8'hEF, 8'h00, 3, 1'b0);

`ifdef SPI_CMD_AUTOINC_EN
    do_reset();
    spi_cs_n = 1'b0;
    repeat (10) @(negedge clk);
    run_cmd(8'h11, 8'hFF, 8'hFF, 8'h01, 4, 1'b0);
    run_cmd(8'h30, 8'h02, 8'h00, 8'h00, 2, 1'b0);
    run_cmd(8'h40, 8'h00, 8'h00, 8'h00, 1, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      if (i == 20) begin
        do_reset();
        spi_cs_n = 1'b0;
        repeat (10) @(negedge clk);
      end
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      op = 4'h0;
      else if (sel <= 3) op = 4'h1;
      else if (sel <= 6) op = 4'h2;
      else if (sel == 7) op = 4'h3;
      else if (sel == 8) op = 4'h4;
      else               op = 4'($urandom_range(5, 15));
      run_cmd({op, 3'($urandom), 1'($urandom)}, 8'($urandom), 8'($urandom), 8'($urandom),
              cmd_len(op), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
